// File: rtl/pos_catch_scorer.sv
// Catch-game scorer: edge-detects start/btn, compares the shifter position with the target,
// keeps BCD score and lives, and drives the shifter direction flag. Optional macro: SCORE_PENALTY_EN.
module pos_catch_scorer #(
  parameter int WIDTH     = 4,
  parameter int LIVES     = 3,
  parameter int WIN_SCORE = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             btn_i,
  input  logic [WIDTH-1:0] pos_i,
  input  logic [WIDTH-1:0] target_i,
  output logic             flag_o,
  output logic [7:0]       score_bcd_o,
  output logic [1:0]       lives_o,
  output logic [1:0]       state_o,
  output logic             hit_o,
  output logic             miss_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_OVER = 2'b10,
    S_WIN  = 2'b11
  } state_t;

  localparam logic [3:0] WIN_TENS   = 4'(WIN_SCORE / 10);
  localparam logic [3:0] WIN_ONES   = 4'(WIN_SCORE % 10);
  localparam logic [7:0] WIN_BCD    = {WIN_TENS, WIN_ONES};
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_t     state_q, state_d;
  logic [7:0] score_q, score_d;
  logic [1:0] lives_q, lives_d;
  logic       flag_q, flag_d;
  logic       hit_q, hit_d;
  logic       miss_q, miss_d;
  logic       start_q, btn_q;

  logic press, go, target_onehot, catch_ok;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)            r = v;
    else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h00)            r = v;
    else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
    else                       r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  assign press         = btn_i & ~btn_q;
  assign go            = start_i & ~start_q;
  assign target_onehot = (target_i != '0) && ((target_i & (target_i - WIDTH'(1))) == '0);
  assign catch_ok      = target_onehot && (pos_i == target_i);

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    flag_d  = flag_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (press) begin
          if (catch_ok) begin
            score_d = bcd_inc(score_q);
            flag_d  = ~flag_q;
            hit_d   = 1'b1;
            if (score_d == WIN_BCD) state_d = S_WIN;
          end else begin
            lives_d = lives_q - 2'd1;
            miss_d  = 1'b1;
`ifdef SCORE_PENALTY_EN
            score_d = bcd_dec(score_q);
`else
            score_d = score_q;
`endif
            if (lives_d == 2'd0) state_d = S_OVER;
          end
        end
      end
      default: begin
        // IDLE/OVER/WIN: only a start edge matters; flag keeps its last value until then
        if (go) begin
          state_d = S_RUN;
          score_d = 8'h00;
          lives_d = LIVES_INIT;
          flag_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      score_q <= 8'h00;
      lives_q <= LIVES_INIT;
      flag_q  <= 1'b1;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      start_q <= 1'b0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      flag_q  <= flag_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      start_q <= start_i;
      btn_q   <= btn_i;
    end
  end

  assign flag_o      = flag_q;
  assign score_bcd_o = score_q;
  assign lives_o     = lives_q;
  assign state_o     = state_q;
  assign hit_o       = hit_q;
  assign miss_o      = miss_q;

endmodule

// File: tb/tb_pos_catch_scorer.sv
// Self-checking bench for pos_catch_scorer: directed scenarios plus random play against a
// decimal-arithmetic game model.
module tb_pos_catch_scorer;

  localparam int LIVES = 3;
  localparam int WIN   = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       btn = 1'b0;
  logic [3:0] pos = 4'b0000;
  logic [3:0] target = 4'b0000;
  logic       flag, hit, miss;
  logic [7:0] score_bcd;
  logic [1:0] lives, state;

  int checks = 0;
  int errors = 0;

  // model state: plain integers, decimal score
  int m_state, m_score, m_lives;
  bit m_flag, m_hit, m_miss, m_start, m_btn;

  pos_catch_scorer #(.WIDTH(4), .LIVES(LIVES), .WIN_SCORE(WIN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .btn_i(btn),
    .pos_i(pos), .target_i(target), .flag_o(flag), .score_bcd_o(score_bcd),
    .lives_o(lives), .state_o(state), .hit_o(hit), .miss_o(miss)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] dut_vec();
    return {state, lives, score_bcd, flag, hit, miss};
  endfunction

  function automatic logic [14:0] exp_vec();
    return {2'(m_state), 2'(m_lives), 4'(m_score / 10), 4'(m_score % 10), m_flag, m_hit, m_miss};
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_lives = LIVES; m_flag = 1'b1;
    m_hit = 1'b0; m_miss = 1'b0; m_start = 1'b0; m_btn = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit b, input logic [3:0] p, input logic [3:0] t);
    bit pr, g;
    pr = b && !m_btn;
    g  = s && !m_start;
    m_hit = 1'b0;
    m_miss = 1'b0;
    if (m_state != 1) begin
      if (g) begin
        m_state = 1; m_score = 0; m_lives = LIVES; m_flag = 1'b1;
      end
    end else if (pr) begin
      if ($countones(t) == 1 && p == t) begin
        if (m_score < 99) m_score = m_score + 1;
        m_flag = !m_flag;
        m_hit = 1'b1;
        if (m_score == WIN) m_state = 3;
      end else begin
        m_lives = m_lives - 1;
        m_miss = 1'b1;
`ifdef SCORE_PENALTY_EN
        if (m_score > 0) m_score = m_score - 1;
`endif
        if (m_lives == 0) m_state = 2;
      end
    end
    m_start = s;
    m_btn = b;
  endtask

  task automatic drive(input bit s, input bit b, input logic [3:0] p, input logic [3:0] t);
    @(negedge clk);
    start = s; btn = b; pos = p; target = t;
    @(posedge clk);
    model_step(s, b, p, t);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if (dut_vec() !== 15'b00_11_00000000_1_0_0) begin
      errors++;
      $display("FAIL reset_values: got %b, expected %b", dut_vec(), 15'b00_11_00000000_1_0_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_start_and_btn();
    drive(1'b1, 1'b1, 4'b0100, 4'b0100);
    checks++;
    if (dut_vec() !== exp_vec() || state !== 2'b01 || hit !== 1'b0 || miss !== 1'b0) begin
      errors++;
      $display("FAIL start_with_btn: got %b, expected %b", dut_vec(), exp_vec());
    end
    drive(1'b0, 1'b0, 4'b0100, 4'b0100);
  endtask

  task automatic test_single_hit_held();
    int hits = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 4'b0100, 4'b0100);
      hits += int'(hit);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL held_btn_cycle%0d: got %b, expected %b", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (hits !== 1 || score_bcd !== 8'h01 || flag !== 1'b0) begin
      errors++;
      $display("FAIL held_btn_once: hits %0d score %h flag %b, expected 1 01 0", hits, score_bcd, flag);
    end
    drive(1'b0, 1'b0, 4'b0100, 4'b0100);
  endtask

  task automatic test_misses_to_over();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1, 4'b0010, 4'b1000);
      checks++;
      if (dut_vec() !== exp_vec() || lives !== 2'(3 - i) || miss !== 1'b1) begin
        errors++;
        $display("FAIL miss_%0d: got %b, expected %b", i, dut_vec(), exp_vec());
      end
      drive(1'b0, 1'b0, 4'b0010, 4'b1000);
    end
    checks++;
    if (state !== 2'b10) begin
      errors++;
      $display("FAIL over_state: got %b, expected 10", state);
    end
    drive(1'b0, 1'b1, 4'b0010, 4'b0010);
    checks++;
    if (dut_vec() !== exp_vec() || hit !== 1'b0 || state !== 2'b10) begin
      errors++;
      $display("FAIL btn_in_over: got %b, expected %b", dut_vec(), exp_vec());
    end
    drive(1'b0, 1'b0, 4'b0010, 4'b0010);
  endtask

  task automatic test_restart_from_over();
    drive(1'b1, 1'b0, 4'b0001, 4'b0001);
    checks++;
    if (dut_vec() !== exp_vec() || state !== 2'b01 || lives !== 2'd3 || score_bcd !== 8'h00) begin
      errors++;
      $display("FAIL restart_over: got %b, expected %b", dut_vec(), exp_vec());
    end
    drive(1'b0, 1'b0, 4'b0001, 4'b0001);
  endtask

  task automatic test_win();
    for (int i = 1; i <= WIN; i++) begin
      drive(1'b0, 1'b1, 4'b1000, 4'b1000);
      checks++;
      if (dut_vec() !== exp_vec() || (i == 10 && score_bcd !== 8'h10)) begin
        errors++;
        $display("FAIL win_hit_%0d: got %b, expected %b", i, dut_vec(), exp_vec());
      end
      drive(1'b0, 1'b0, 4'b1000, 4'b1000);
    end
    checks++;
    if (state !== 2'b11 || score_bcd !== 8'h20) begin
      errors++;
      $display("FAIL win_state: state %b score %h, expected 11 20", state, score_bcd);
    end
    drive(1'b0, 1'b1, 4'b1000, 4'b1000);
    checks++;
    if (hit !== 1'b0 || score_bcd !== 8'h20 || state !== 2'b11) begin
      errors++;
      $display("FAIL press_after_win: got %b, expected %b", dut_vec(), exp_vec());
    end
    drive(1'b0, 1'b0, 4'b1000, 4'b1000);
  endtask

  task automatic test_invalid_targets();
    logic [7:0] exp_sc;
    drive(1'b1, 1'b0, 4'b0001, 4'b0001);
    drive(1'b0, 1'b0, 4'b0001, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 4'b0001, 4'b0001);
      drive(1'b0, 1'b0, 4'b0001, 4'b0001);
    end
    drive(1'b0, 1'b1, 4'b0100, 4'b0110);
`ifdef SCORE_PENALTY_EN
    exp_sc = 8'h09;
`else
    exp_sc = 8'h10;
`endif
    checks++;
    if (dut_vec() !== exp_vec() || miss !== 1'b1 || hit !== 1'b0 || score_bcd !== exp_sc) begin
      errors++;
      $display("FAIL invalid_target: got %b, expected %b", dut_vec(), exp_vec());
    end
    drive(1'b0, 1'b0, 4'b0000, 4'b0100);
    drive(1'b0, 1'b1, 4'b0000, 4'b0000);
    checks++;
    if (dut_vec() !== exp_vec() || miss !== 1'b1 || lives !== 2'd1) begin
      errors++;
      $display("FAIL pos_zero: got %b, expected %b", dut_vec(), exp_vec());
    end
    drive(1'b0, 1'b0, 4'b0000, 4'b0000);
    drive(1'b0, 1'b1, 4'b0000, 4'b0001);
    drive(1'b0, 1'b0, 4'b0000, 4'b0001);
    drive(1'b1, 1'b0, 4'b0000, 4'b0001);
    drive(1'b0, 1'b1, 4'b0010, 4'b0001);
    checks++;
    if (dut_vec() !== exp_vec() || score_bcd !== 8'h00 || miss !== 1'b1) begin
      errors++;
      $display("FAIL miss_at_zero: got %b, expected %b", dut_vec(), exp_vec());
    end
    drive(1'b0, 1'b0, 4'b0010, 4'b0001);
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 4'b0010, 4'b0010);
      drive(1'b0, 1'b0, 4'b0010, 4'b0010);
    end
    checks++;
    if (dut_vec() !== exp_vec() || score_bcd !== 8'h05) begin
      errors++;
      $display("FAIL pre_reset_score: got %b, expected %b", dut_vec(), exp_vec());
    end
    @(negedge clk);
    btn = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 15'b00_11_00000000_1_0_0) begin
      errors++;
      $display("FAIL async_reset: got %b, expected %b", dut_vec(), 15'b00_11_00000000_1_0_0);
    end
    @(negedge clk);
    btn = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit s, b;
    logic [3:0] p, t;
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 11) == 0);
      b = 1'(($urandom_range(0, 2)) != 0);
      p = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
      t = ($urandom_range(0, 2) != 0) ? p : 4'($urandom_range(0, 15));
      drive(s, b, p, t);
      checks++;
      if (dut_vec() !== exp_vec() || (hit && miss)) begin
        errors++;
        $display("FAIL random_cycle%0d: got %b, expected %b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_and_btn();
    test_single_hit_held();
    test_misses_to_over();
    test_restart_from_over();
    test_win();
    test_invalid_targets();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
